// File: rtl/mips_pkg.sv
// Shared MIPS front-end constants and the fetch sequencer state type.
package mips_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO between fetch and decode. Supports push+pop when full
// and a flush that empties the queue. The head is kept in a dedicated register.
module fetch_queue #(
    parameter int PW     = 64,
    parameter int QDEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [PW-1:0]                push_data,
    output logic [$clog2(QDEPTH+1)-1:0]  count,
    output logic                         head_valid,
    output logic [PW-1:0]                head_data
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = $clog2(QDEPTH+1);

    logic [PW-1:0]    r_mem [QDEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [PW-1:0]    r_head;

    logic             w_full;
    logic             w_do_pop;
    logic             w_do_push;
    logic [PTR_W-1:0] w_rd_next;
    logic [CNT_W-1:0] w_remain;
    logic [PW-1:0]    w_head_next;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QDEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch can be inferred.
        w_full      = (r_count == CNT_W'(QDEPTH));
        w_do_pop    = pop & (r_count != '0) & ~flush;
        w_do_push   = push & ~flush & (~w_full | w_do_pop);
        w_rd_next   = w_do_pop ? ptr_inc(r_rd_ptr) : r_rd_ptr;
        w_remain    = r_count - CNT_W'(w_do_pop);
        w_head_next = r_head;
        // The head tracks the oldest entry; with nothing left it keeps its last value.
        if (w_do_push && (w_remain == '0)) begin
            w_head_next = push_data;
        end else if (w_remain != '0) begin
            w_head_next = r_mem[w_rd_next];
        end
    end

    // NOTE: entry storage is not reset; the head register alone gives defined outputs after reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else if (flush) begin
            // Read pointer stays put so the head register keeps showing the last word.
            r_wr_ptr <= r_rd_ptr;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= w_rd_next;
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
            r_head  <= w_head_next;
        end
    end

    assign count      = r_count;
    assign head_valid = (r_count != '0);
    assign head_data  = r_head;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, range-checks it against instruction memory,
// and feeds fetched {pc, instr} pairs into the decode queue.
module imem_fetch_ctrl
    import mips_pkg::*;
#(
    parameter int               WIDTH    = DATA_WIDTH,
    parameter int               DEPTH    = 100,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               QDEPTH   = 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             dec_ready,
    output logic             dec_valid,
    output logic [WIDTH-1:0] dec_instr,
    output logic [WIDTH-1:0] dec_pc,
    output logic [WIDTH-1:0] dec_pc_plus4,
    output logic             fault
);

    localparam int CNT_W   = $clog2(QDEPTH+1);
    localparam int BYTE_SH = $clog2(INSTR_BYTES);

    logic [WIDTH-1:0] r_fetch_pc;
    fetch_state_e     r_state;
    logic             r_fault;
    logic             r_head_loaded;

    logic [WIDTH-1:0]   w_word_idx;
    logic               w_aligned;
    logic               w_in_range;
    logic               w_fetch_ok;
    logic               w_bad_pc;
    logic               w_pop;
    logic               w_push;
    logic [CNT_W-1:0]   w_count;
    logic               w_head_valid;
    logic [2*WIDTH-1:0] w_head_data;

    assign w_word_idx = r_fetch_pc >> BYTE_SH;
    assign w_aligned  = (r_fetch_pc[BYTE_SH-1:0] == '0);
    assign w_in_range = (w_word_idx < WIDTH'(DEPTH));
    assign w_fetch_ok = (r_state == ST_RUN) & w_aligned & w_in_range;
    assign w_bad_pc   = (r_state == ST_RUN) & ~(w_aligned & w_in_range);
    assign w_pop      = w_head_valid & dec_ready;
    assign w_push     = w_fetch_ok & ~redirect_valid & ((w_count < CNT_W'(QDEPTH)) | w_pop);

    fetch_queue #(
        .PW     (2*WIDTH),
        .QDEPTH (QDEPTH)
    ) u_fetch_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (w_push),
        .pop        (w_pop),
        .flush      (redirect_valid),
        .push_data  ({r_fetch_pc, imem_rdata}),
        .count      (w_count),
        .head_valid (w_head_valid),
        .head_data  (w_head_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_state    <= ST_RUN;
            r_fault    <= 1'b0;
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
            r_state    <= ST_RUN;
            r_fault    <= 1'b0;
        end else if (r_state == ST_RUN) begin
            // A bad PC freezes fetch_pc at the offending address for debug.
            if (w_bad_pc) begin
                r_state <= ST_FAULT;
                r_fault <= 1'b1;
            end else if (w_push) begin
                r_fetch_pc <= r_fetch_pc + WIDTH'(INSTR_BYTES);
            end
        end
    end

    // Until the first word lands, the head register is zero and pc+4 must read zero too.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_loaded <= 1'b0;
        end else if (w_push) begin
            r_head_loaded <= 1'b1;
        end
    end

    assign imem_addr    = r_fetch_pc;
    assign dec_valid    = w_head_valid;
    assign dec_pc       = w_head_data[2*WIDTH-1:WIDTH];
    assign dec_instr    = w_head_data[WIDTH-1:0];
    assign dec_pc_plus4 = r_head_loaded ? dec_pc + WIDTH'(INSTR_BYTES) : '0;
    assign fault        = r_fault;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: one instance with DEPTH=100 for streaming,
// stall, redirect and misalignment, one with DEPTH=4 for running off the end.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;

    logic [31:0] a_addr, a_rdata, a_redirect_pc, a_instr, a_pc, a_pc4;
    logic        a_redirect, a_ready, a_valid, a_fault;
    logic [31:0] b_addr, b_rdata, b_redirect_pc, b_instr, b_pc, b_pc4;
    logic        b_redirect, b_ready, b_valid, b_fault;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        logic [31:0] idx;
        idx = addr >> 2;
        if (idx == 32'd0) return 32'h2008_0005;
        if (idx == 32'd1) return 32'h2009_0003;
        return 32'h2000_0000 | idx;
    endfunction

    assign a_rdata = mem_word(a_addr);
    assign b_rdata = mem_word(b_addr);

    imem_fetch_ctrl #(.WIDTH(32), .DEPTH(100), .RESET_PC(32'h0), .QDEPTH(2)) u_dut_a (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (a_addr),
        .imem_rdata     (a_rdata),
        .redirect_valid (a_redirect),
        .redirect_pc    (a_redirect_pc),
        .dec_ready      (a_ready),
        .dec_valid      (a_valid),
        .dec_instr      (a_instr),
        .dec_pc         (a_pc),
        .dec_pc_plus4   (a_pc4),
        .fault          (a_fault)
    );

    imem_fetch_ctrl #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h0), .QDEPTH(2)) u_dut_b (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (b_addr),
        .imem_rdata     (b_rdata),
        .redirect_valid (b_redirect),
        .redirect_pc    (b_redirect_pc),
        .dec_ready      (b_ready),
        .dec_valid      (b_valid),
        .dec_instr      (b_instr),
        .dec_pc         (b_pc),
        .dec_pc_plus4   (b_pc4),
        .fault          (b_fault)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        a_redirect = 1'b0; a_redirect_pc = 32'h0; a_ready = 1'b0;
        b_redirect = 1'b0; b_redirect_pc = 32'h0; b_ready = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_valid", 32'(a_valid), 32'h0);
        check("rst_instr", a_instr, 32'h0);
        check("rst_pc", a_pc, 32'h0);
        check("rst_pc4", a_pc4, 32'h0);
        check("rst_addr", a_addr, 32'h0);
        check("rst_fault", 32'(a_fault), 32'h0);
        check("rst_b_valid", 32'(b_valid), 32'h0);

        // Streaming with dec_ready held high
        rst = 1'b0; a_ready = 1'b1;
        tick();
        check("s0_valid", 32'(a_valid), 32'h1);
        check("s0_pc", a_pc, 32'h0);
        check("s0_instr", a_instr, 32'h2008_0005);
        check("s0_pc4", a_pc4, 32'h4);
        check("s0_addr", a_addr, 32'h4);
        tick();
        check("s1_pc", a_pc, 32'h4);
        check("s1_instr", a_instr, 32'h2009_0003);
        check("s1_pc4", a_pc4, 32'h8);
        tick();
        check("s2_pc", a_pc, 32'h8);
        check("s2_instr", a_instr, 32'h2000_0002);
        tick();
        check("s3_pc", a_pc, 32'hC);
        check("s3_instr", a_instr, 32'h2000_0003);
        tick();
        check("s4_pc", a_pc, 32'h10);
        check("s4_instr", a_instr, 32'h2000_0004);
        check("s4_pc4", a_pc4, 32'h14);
        check("s4_addr", a_addr, 32'h14);

        // Stall after first delivery
        rst = 1'b1; tick(); rst = 1'b0;
        tick();
        check("st_first_pc", a_pc, 32'h0);
        tick();
        check("st_second_pc", a_pc, 32'h4);
        a_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("st_hold_valid", 32'(a_valid), 32'h1);
            check("st_hold_pc", a_pc, 32'h4);
            check("st_hold_addr", a_addr, 32'hC);
        end
        a_ready = 1'b1;
        tick();
        check("st_res0_pc", a_pc, 32'h8);
        tick();
        check("st_res1_pc", a_pc, 32'hC);
        tick();
        check("st_res2_pc", a_pc, 32'h10);
        check("st_res2_addr", a_addr, 32'h18);

        // Redirect while full with dec_ready high
        a_redirect = 1'b1; a_redirect_pc = 32'h40;
        tick();
        check("rd_valid", 32'(a_valid), 32'h0);
        check("rd_addr", a_addr, 32'h40);
        check("rd_pc_hold", a_pc, 32'h10);
        a_redirect = 1'b0;
        tick();
        check("rd_tgt_valid", 32'(a_valid), 32'h1);
        check("rd_tgt_pc", a_pc, 32'h40);
        check("rd_tgt_instr", a_instr, 32'h2000_0010);
        tick();
        check("rd_next_pc", a_pc, 32'h44);
        check("rd_next_instr", a_instr, 32'h2000_0011);

        // Misaligned redirect target
        a_redirect = 1'b1; a_redirect_pc = 32'h6;
        tick();
        check("mis_fault_0", 32'(a_fault), 32'h0);
        check("mis_addr_0", a_addr, 32'h6);
        a_redirect = 1'b0;
        tick();
        check("mis_fault_1", 32'(a_fault), 32'h1);
        check("mis_valid_1", 32'(a_valid), 32'h0);
        check("mis_addr_1", a_addr, 32'h6);
        tick();
        check("mis_fault_2", 32'(a_fault), 32'h1);
        check("mis_valid_2", 32'(a_valid), 32'h0);
        a_redirect = 1'b1; a_redirect_pc = 32'h8;
        tick();
        check("mis_clr_fault", 32'(a_fault), 32'h0);
        check("mis_clr_addr", a_addr, 32'h8);
        a_redirect = 1'b0;
        tick();
        check("mis_clr_valid", 32'(a_valid), 32'h1);
        check("mis_clr_pc", a_pc, 32'h8);
        check("mis_clr_instr", a_instr, 32'h2000_0002);
        a_redirect = 1'b1; a_redirect_pc = 32'h6;
        tick();
        a_redirect = 1'b0;
        tick();
        check("mis_refault", 32'(a_fault), 32'h1);

        // Reset with simultaneous redirect during FAULT
        rst = 1'b1; a_redirect = 1'b1; a_redirect_pc = 32'h40;
        tick();
        check("rr_fault", 32'(a_fault), 32'h0);
        check("rr_addr", a_addr, 32'h0);
        check("rr_valid", 32'(a_valid), 32'h0);
        check("rr_pc", a_pc, 32'h0);
        check("rr_pc4", a_pc4, 32'h0);
        rst = 1'b0; a_redirect = 1'b0;

        // Run off the end of a 4-word memory
        b_ready = 1'b1;
        tick(); tick(); tick();
        check("end_pc_8", b_pc, 32'h8);
        b_ready = 1'b0;
        tick();
        check("end_addr_10", b_addr, 32'h10);
        check("end_nofault", 32'(b_fault), 32'h0);
        tick();
        check("end_fault", 32'(b_fault), 32'h1);
        check("end_addr_hold", b_addr, 32'h10);
        check("end_valid", 32'(b_valid), 32'h1);
        check("end_head_pc", b_pc, 32'h8);
        b_ready = 1'b1;
        tick();
        check("end_drain_pc", b_pc, 32'hC);
        check("end_drain_instr", b_instr, 32'h2000_0003);
        check("end_drain_pc4", b_pc4, 32'h10);
        check("end_drain_fault", 32'(b_fault), 32'h1);
        tick();
        check("end_empty_valid", 32'(b_valid), 32'h0);
        check("end_empty_addr", b_addr, 32'h10);
        tick();
        check("end_stay_valid", 32'(b_valid), 32'h0);
        check("end_stay_fault", 32'(b_fault), 32'h1);
        b_redirect = 1'b1; b_redirect_pc = 32'h0;
        tick();
        check("end_rd_fault", 32'(b_fault), 32'h0);
        check("end_rd_addr", b_addr, 32'h0);
        check("end_rd_valid", 32'(b_valid), 32'h0);
        b_redirect = 1'b0;
        tick();
        check("end_restart_valid", 32'(b_valid), 32'h1);
        check("end_restart_pc", b_pc, 32'h0);
        check("end_restart_instr", b_instr, 32'h2008_0005);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
